booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier with its datapath and control FSM in one block. Operand width is set by a parameter, and a per-operation mode input selects signed (two's-complement) or unsigned multiplication. It runs one Booth step per clock and gives a fixed, width-derived latency. It uses a start/busy/done handshake and serves as the general multiply unit in the arithmetic section.

---
 rtl/booth_mult_seq.sv | 125 ++++++++++++
 tb/tb_booth_mult_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Sequential radix-2 Booth multiplier, signed/unsigned per operation.
// Revision : 1.0
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_W1 = WIDTH + 1;
    localparam int c_CW = $clog2(c_W1 + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [c_W1-1:0]        m_q, m_d;
    logic [c_W1-1:0]        q_q, q_d;
    logic [c_W1:0]          a_q, a_d;
    logic                   q1_q, q1_d;
    logic [c_CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [c_W1:0]          w_m_ext;
    logic [c_W1:0]          w_sum;
    logic [c_W1:0]          w_a_sh;
    logic [c_W1-1:0]        w_q_sh;

    // The extra operand bit lets one signed Booth recoding serve both modes.
    assign w_m_ext = {m_q[c_W1-1], m_q};

    always_comb begin
        w_sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   w_sum = a_q + w_m_ext;
            2'b10:   w_sum = a_q - w_m_ext;
            default: w_sum = a_q;
        endcase
    end

    assign w_a_sh = {w_sum[c_W1], w_sum[c_W1:1]};
    assign w_q_sh = {w_sum[0], q_q[c_W1-1:1]};

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        a_d       = a_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = tc ? {a[WIDTH-1], a} : {1'b0, a};
                    q_d     = tc ? {b[WIDTH-1], b} : {1'b0, b};
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = c_CW'(c_W1);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = w_a_sh;
                q_d   = w_q_sh;
                q1_d  = q_q[0];
                cnt_d = cnt_q - c_CW'(1);
                if (cnt_q == c_CW'(1)) begin
                    product_d = {w_a_sh[WIDTH-2:0], w_q_sh};
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            a_q       <= a_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_seq
// Brief    : Self-checking bench for booth_mult_seq at WIDTH 4, 8 and 16.
// Revision : 1.0
// ============================================================================
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, tc = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        busy, done;
    logic [15:0] product;

    logic        s4 = 1'b0, t4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  p4;

    logic        s16 = 1'b0, t16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .tc(tc), .a(a), .b(b),
        .busy(busy), .done(done), .product(product));

    booth_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .tc(t4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(p4));

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .tc(t16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(p16));

    // Reference: mathematical product of the operands, reduced to 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input bit t,
                                            input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy;
        logic [63:0] r, msk;
        sx = longint'(x);
        sy = longint'(y);
        if (t && x[w-1]) sx = sx - (longint'(1) << w);
        if (t && y[w-1]) sy = sy - (longint'(1) << w);
        r   = sx * sy;
        msk = (64'd1 << (2 * w)) - 64'd1;
        return r & msk;
    endfunction

    // Runs one operation on the WIDTH=8 unit; returns the result, the latency
    // in edges after acceptance, and busy/done one cycle after the done pulse.
    task automatic run_op(input bit t, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int lat,
                          output logic busy_acc, output logic d_next, output logic b_next);
        tc = t; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_acc = busy;
        a = 8'($urandom); b = 8'($urandom); tc = 1'($urandom);
        lat = 0; p = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n; p = product;
                break;
            end
        end
        @(posedge clk); #1;
        d_next = done; b_next = busy;
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h, expected 0 0 0000", busy, done, product);
        end
    endtask

    task automatic test_signed;
        logic [15:0] p; int lat; logic ba, dn, bn;
        run_op(1'b1, 8'hF9, 8'h03, p, lat, ba, dn, bn);
        checks++; if (p !== 16'hFFEB) begin errors++; $display("FAIL signed_prod: got %h expected FFEB", p); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL signed_latency: got %0d expected 9", lat); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", ba); end
        checks++; if (dn !== 1'b0 || bn !== 1'b0) begin errors++; $display("FAIL done_width: done=%b busy=%b expected 0 0", dn, bn); end
    endtask

    task automatic test_extremes;
        logic [15:0] p; int lat; logic ba, dn, bn;
        run_op(1'b0, 8'hFF, 8'hFF, p, lat, ba, dn, bn);
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL unsigned_ff: got %h expected FE01", p); end
        run_op(1'b1, 8'hFF, 8'hFF, p, lat, ba, dn, bn);
        checks++; if (p !== 16'h0001) begin errors++; $display("FAIL signed_m1: got %h expected 0001", p); end
    endtask

    task automatic test_most_negative;
        logic [15:0] p; int lat; logic ba, dn, bn;
        run_op(1'b1, 8'h80, 8'h80, p, lat, ba, dn, bn);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL mn_x_mn: got %h expected 4000", p); end
        run_op(1'b1, 8'h80, 8'h7F, p, lat, ba, dn, bn);
        checks++; if (p !== 16'hC080) begin errors++; $display("FAIL mn_x_max: got %h expected C080", p); end
        run_op(1'b1, 8'h00, 8'h80, p, lat, ba, dn, bn);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_x_mn: got %h expected 0000", p); end
    endtask

    task automatic test_ignore_start;
        logic [15:0] prev; int lat;
        prev = product;
        tc = 1'b0; a = 8'h05; b = 8'h06; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3) begin start = 1'b1; tc = 1'b1; a = 8'hAA; b = 8'h55; end
            if (n == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = n; break; end
            checks++;
            if (product !== prev) begin
                errors++; $display("FAIL product_hold: cycle %0d got %h expected %h", n, product, prev);
            end
        end
        checks++; if (lat !== 9) begin errors++; $display("FAIL ignore_latency: got %0d expected 9", lat); end
        checks++; if (product !== 16'h001E) begin errors++; $display("FAIL ignore_prod: got %h expected 001E", product); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL start_queued: busy=%b expected 0", busy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] xa[3] = '{8'h03, 8'h10, 8'hC8};
        logic [7:0] xb[3] = '{8'h04, 8'h11, 8'h02};
        logic [15:0] xp[3] = '{16'h000C, 16'h0110, 16'h0190};
        int i = 0, cyc = 0, last = -1;
        tc = 1'b0; a = xa[0]; b = xb[0]; start = 1'b1;
        for (int n = 0; n < 60 && i < 3; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                checks++;
                if (product !== xp[i]) begin errors++; $display("FAIL b2b_prod%0d: got %h expected %h", i, product, xp[i]); end
                if (i > 0) begin
                    checks++;
                    if (cyc - last !== 11) begin errors++; $display("FAIL b2b_interval%0d: got %0d expected 11", i, cyc - last); end
                end
                last = cyc;
                i++;
                if (i < 3) begin a = xa[i]; b = xb[i]; end
            end
        end
        start = 1'b0;
        checks++;
        if (i !== 3) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 3", i); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [15:0] p; int lat; logic ba, dn, bn;
        tc = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
            errors++; $display("FAIL reset_mid: busy=%b done=%b product=%h expected 0 0 0000", busy, done, product);
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (n == 1) rst_n = 1'b1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL abort_done: done=%b expected 0", done); end
        end
        run_op(1'b0, 8'h0C, 8'h0D, p, lat, ba, dn, bn);
        checks++; if (p !== 16'h009C) begin errors++; $display("FAIL post_reset_prod: got %h expected 009C", p); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL post_reset_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_random_sweep;
        logic [63:0] e4, e8, e16;
        for (int it = 0; it < 2000; it++) begin
            a4 = 4'($urandom);   b4 = 4'($urandom);   t4 = 1'($urandom);
            a = 8'($urandom);    b = 8'($urandom);    tc = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); t16 = 1'($urandom);
            e4  = ref_mul(4,  t4,  32'(a4),  32'(b4));
            e8  = ref_mul(8,  tc,  32'(a),   32'(b));
            e16 = ref_mul(16, t16, 32'(a16), 32'(b16));
            s4 = 1'b1; start = 1'b1; s16 = 1'b1;
            @(posedge clk); #1;
            s4 = 1'b0; start = 1'b0; s16 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); t4 = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom); tc = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); t16 = 1'($urandom);
            for (int c = 1; c <= 18; c++) begin
                @(posedge clk); #1;
                checks++;
                if (done4 !== (c == 5) || done !== (c == 9) || done16 !== (c == 17)) begin
                    errors++;
                    $display("FAIL rand_done: it %0d cycle %0d done4=%b done8=%b done16=%b", it, c, done4, done, done16);
                end
                if (c == 5) begin
                    checks++;
                    if (p4 !== e4[7:0]) begin errors++; $display("FAIL rand_w4: got %h expected %h", p4, e4[7:0]); end
                end
                if (c == 9) begin
                    checks++;
                    if (product !== e8[15:0]) begin errors++; $display("FAIL rand_w8: got %h expected %h", product, e8[15:0]); end
                end
                if (c == 17) begin
                    checks++;
                    if (p16 !== e16[31:0]) begin errors++; $display("FAIL rand_w16: got %h expected %h", p16, e16[31:0]); end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        test_signed;
        test_extremes;
        test_most_negative;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_random_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
